alu_seq16: RTL

ALU_SEQ16 -- requirements
Module: alu_seq16

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq16_cla4_slice.sv | 39 +++
 rtl/alu_seq16.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_pkg                                                  |
// | Description : Shared types and constants for the nibble-serial 16-bit      |
// |               adder/subtractor (alu_seq16) and its 4-bit CLA slice.        |
// |               Provides the state encoding (IDLE/RUN/DONE), the datapath    |
// |               width and the number of nibble passes per operation.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_seq_pkg;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = 4;
  localparam int CNT_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq16_cla4_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla4_slice                                                   |
// | Description : Purely combinational 4-bit carry-lookahead adder slice.      |
// |               Ports: a[3:0], b[3:0] addends; ci carry-in;                  |
// |                      s[3:0] sum; co carry-out of bit 3.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_g;  // generate
  logic [3:0] w_p;  // propagate
  logic [4:0] w_c;  // carry into each bit, w_c[4] is the slice carry-out

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is expanded directly from g/p/ci, so no carry ripples
  // through a previous carry term.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];

endmodule
`default_nettype wire

// File: rtl/alu_seq16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq16                                                    |
// | Description : 16-bit add/subtract computed one nibble per cycle through a  |
// |               single 4-bit carry-lookahead slice (LSB nibble first).       |
// |               Ports: clk, rst_n (async, active-low); start, a, b, sub, cin |
// |               request inputs; busy, done, r, co (and ovf) outputs.         |
// |               r/co update only when done pulses and hold until the next.   |
// |               Option ALU_SEQ16_OVF_FLAG_EN adds the signed-overflow output |
// |               ovf, registered and held together with r.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_seq16
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             co
`ifdef ALU_SEQ16_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic [11:0]      shadow_q;  // nibbles 0..2; nibble 3 goes straight to r
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] r_q;
  logic             co_q;
`ifdef ALU_SEQ16_OVF_FLAG_EN
  logic             ovf_q;
  logic             w_c15;
`endif

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_s;
  logic       w_co;

  // Subtraction is a + ~b + 1: invert B here, the +1 is the initial carry.
  assign w_a_nib = a_q[{cnt_q, 2'b00} +: 4];
  assign w_b_nib = b_q[{cnt_q, 2'b00} +: 4] ^ {4{sub_q}};

  cla4_slice u_slice (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .ci (carry_q),
    .s  (w_s),
    .co (w_co)
  );

`ifdef ALU_SEQ16_OVF_FLAG_EN
  // Carry into bit 15 recovered from the top sum bit: s = a ^ b ^ cin.
  assign w_c15 = w_a_nib[3] ^ w_b_nib[3] ^ w_s[3];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= '0;
      co_q     <= 1'b0;
`ifdef ALU_SEQ16_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            cnt_q   <= '0;
            carry_q <= sub ? 1'b1 : cin;
          end
        end

        RUN: begin
          carry_q <= w_co;
          case (cnt_q)
            2'd0:    shadow_q[3:0]  <= w_s;
            2'd1:    shadow_q[7:4]  <= w_s;
            2'd2:    shadow_q[11:8] <= w_s;
            default: ;
          endcase
          if (cnt_q == CNT_W'(NIBBLES - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            r_q     <= {w_s, shadow_q};
            co_q    <= w_co;
`ifdef ALU_SEQ16_OVF_FLAG_EN
            ovf_q   <= w_c15 ^ w_co;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;
  assign co   = co_q;
`ifdef ALU_SEQ16_OVF_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire
